tdc_frame_packer: RTL and testbench
===================================

Name: tdc_frame_packer

Overview:
- Sits between the TDC counter output and the UART transmitter.
- Accepts single-cycle measurement pulses (counter_data/counter_valid) and buffers them in a small FIFO so bursts of start/stop events are not lost while the UART is busy.
- Wraps each measurement in a fixed byte frame and presents it to the UART one byte at a time over a valid/ready handshake.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- counter_data  input  8  TDC measurement; sampled when counter_valid=1
- counter_valid  input  1  one-cycle strobe from TDC; no backpressure possible
- axi_data  output  8  byte to UART
- axi_valid  output  1  axi_data holds a byte to send
- axi_ready  input  1  UART accepts byte; transfer occurs when axi_valid and axi_ready are both 1 on a rising edge
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
- overflow  output  1  sticky: set when a sample is dropped; cleared only by rst
- drop_count  output  8  number of dropped samples; saturates at 255

Behaviour:
- Reset (rst=1 at a clock edge) sets the following, regardless of state:
  - axi_valid=0, axi_data=0, fifo_level=0, overflow=0, drop_count=0.
  - Sequence counter = 0, FSM = IDLE, FIFO pointers cleared.
- Reset mid-frame abandons the frame: axi_valid is 0 in the cycle after the reset edge, and all queued samples are discarded.
- FIFO push:
  - On counter_valid=1, counter_data is written to the FIFO if it is not full.
  - If full, the sample is dropped, overflow is set, and drop_count is incremented (saturating at 255).
  - Push while full and a pop in the same cycle: the push is accepted, because the pop frees the slot in that same edge.
- FIFO pop: occurs only on the IDLE->HDR transition. The popped entry is latched into an internal data register.
- fifo_level counts entries in the FIFO only; the latched in-flight sample is not counted.
- FSM states and transitions:
  - IDLE: axi_valid=0. If FIFO is not empty, pop into the data register and go to HDR.
  - HDR: axi_valid=1, axi_data=HEADER. On transfer, go to SEQ.
  - SEQ: axi_valid=1, axi_data=sequence counter. On transfer, go to DAT.
  - DAT: axi_valid=1, axi_data=latched sample. On transfer, go to CHK if CHECKSUM_EN is defined, otherwise go to IDLE and increment the sequence counter.
  - CHK: axi_valid=1, axi_data=HEADER ^ seq ^ sample. On transfer, go to IDLE and increment the sequence counter.
- Handshake rules:
  - Once axi_valid=1, axi_valid and axi_data stay stable until the transfer.
  - axi_valid does not depend combinationally on axi_ready.
  - Both outputs are registered.
- Sequence counter: 8-bit, wraps 255->0, one increment per completed frame.
- Latency: a sample strobed in cycle N with the FIFO empty and the FSM in IDLE is:
  - visible in fifo_level=1 in cycle N+1;
  - popped at the end of cycle N+1;
  - presented as HEADER with axi_valid=1 in cycle N+2.
- Throughput: one IDLE cycle between back-to-back frames. With axi_ready held at 1, a 3-byte frame therefore takes 4 cycles.
- Simultaneous counter_valid and rst: reset wins and the sample is discarded.

Optional Feature:
- Macro: TDC_FRAME_CHECKSUM_EN.
- Defined: frames are 4 bytes (HEADER, SEQ, DATA, CHK), with CHK = HEADER XOR SEQ XOR DATA.
- Undefined: frames are 3 bytes; the CHK state and its logic are absent.
- Ports and all other behaviour are identical in both builds.

Test Plan:
- Single sample, axi_ready=1 throughout, counter_data=8'h3C in cycle N:
  - axi_valid rises in cycle N+2.
  - Bytes A5,00,3C appear, plus A5^00^3C=99 when TDC_FRAME_CHECKSUM_EN is defined.
  - axi_valid=0 afterwards.
- Backpressure: axi_ready=0 for 5 cycles during SEQ:
  - axi_data stays 8'h00 and axi_valid stays 1 for all 5 cycles.
  - The frame completes normally after axi_ready returns to 1.
- Overflow, DEPTH=8, axi_ready=0, counter_valid pulsed 12 times with data 1..12:
  - fifo_level=8, overflow=1, drop_count=3.
  - Sample 1 is latched in the data register; samples 2..9 are queued and 10..12 are dropped.
  - After releasing axi_ready, frames carry data 1..9 with seq 0..8.
- Sequence wrap: send 257 frames; frame 256 has SEQ=8'hFF and frame 257 has SEQ=8'h00.
- Reset mid-frame:
  - Assert rst while in DAT with 3 samples queued.
  - Next cycle: axi_valid=0 and fifo_level=0.
  - A new sample afterwards produces a frame with SEQ=8'h00.
- Push on full with simultaneous pop, DEPTH=8:
  - FIFO holds 8 entries and the FSM is in IDLE with counter_valid=1 in the same cycle.
  - Result: fifo_level stays 8, drop_count stays 0, overflow stays 0.

Source files
------------

// File: rtl/tdc_frame_packer.sv
// tdc_frame_packer
//   Buffers single-cycle TDC measurements in a small FIFO and sends each one
//   to the UART as a byte frame: HEADER, sequence number, sample and, when
//   TDC_FRAME_CHECKSUM_EN is defined, a checksum byte (HEADER ^ SEQ ^ DATA).
//   The frame bytes use a valid/ready handshake, and the byte outputs are
//   registered.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous reset, active high
//   counter_data  TDC measurement, sampled when counter_valid=1
//   counter_valid one-cycle strobe, no backpressure
//   axi_data      byte to UART
//   axi_valid     axi_data holds a byte to send
//   axi_ready     UART accepts byte (transfer when valid & ready at edge)
//   fifo_level    FIFO occupancy 0..DEPTH (in-flight sample not counted)
//   overflow      sticky, set when a sample is dropped
//   drop_count    dropped samples, saturating at 255
//
// Build option: define TDC_FRAME_CHECKSUM_EN for 4-byte frames with checksum.
module tdc_frame_packer #(
  parameter int unsigned DEPTH  = 8,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             counter_data,
  input  logic                   counter_valid,
  output logic [7:0]             axi_data,
  output logic                   axi_valid,
  input  logic                   axi_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic [7:0]             drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

`ifdef TDC_FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, SEQ, DAT, CHK} state_t;
`else
  typedef enum logic [1:0] {IDLE, HDR, SEQ, DAT} state_t;
`endif

  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     level_q;
  logic [7:0]      data_q;
  logic [7:0]      seq_q, seq_d;
  logic [7:0]      axi_data_q, axi_data_d;
  logic            axi_valid_q, axi_valid_d;
  logic            overflow_q;
  logic [7:0]      drop_q;

  logic pop, push, xfer;

  // A pop on the same edge frees a slot, so a push into a full FIFO still
  // succeeds when the FSM is pulling an entry at that moment.
  assign pop  = (state_q == IDLE) && (level_q != '0);
  assign push = counter_valid && ((level_q != FULL_LVL) || pop);
  assign xfer = axi_valid_q && axi_ready;

  always_comb begin
    state_d     = state_q;
    axi_valid_d = axi_valid_q;
    axi_data_d  = axi_data_q;
    seq_d       = seq_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d     = HDR;
          axi_valid_d = 1'b1;
          axi_data_d  = HEADER;
        end
      end
      HDR: begin
        if (xfer) begin
          state_d    = SEQ;
          axi_data_d = seq_q;
        end
      end
      SEQ: begin
        if (xfer) begin
          state_d    = DAT;
          axi_data_d = data_q;
        end
      end
      DAT: begin
        if (xfer) begin
`ifdef TDC_FRAME_CHECKSUM_EN
          state_d    = CHK;
          axi_data_d = HEADER ^ seq_q ^ data_q;
`else
          state_d     = IDLE;
          axi_valid_d = 1'b0;
          axi_data_d  = '0;
          seq_d       = seq_q + 8'd1;
`endif
        end
      end
`ifdef TDC_FRAME_CHECKSUM_EN
      CHK: begin
        if (xfer) begin
          state_d     = IDLE;
          axi_valid_d = 1'b0;
          axi_data_d  = '0;
          seq_d       = seq_q + 8'd1;
        end
      end
`endif
      default: begin
        state_d     = IDLE;
        axi_valid_d = 1'b0;
        axi_data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      data_q      <= '0;
      seq_q       <= '0;
      axi_data_q  <= '0;
      axi_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      axi_data_q  <= axi_data_d;
      axi_valid_q <= axi_valid_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        data_q   <= mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (counter_valid && !push) begin
        overflow_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= counter_data;
  end

  assign axi_data   = axi_data_q;
  assign axi_valid  = axi_valid_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_tdc_frame_packer.sv
// Testbench for tdc_frame_packer: directed scenarios plus randomized traffic
// checked against a transaction-level model (sample queue + pending frame bytes).
module tb_tdc_frame_packer;

  localparam int unsigned DEPTH  = 8;
  localparam logic [7:0]  HEADER = 8'hA5;
`ifdef TDC_FRAME_CHECKSUM_EN
  localparam int FL = 4;
`else
  localparam int FL = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] counter_data = '0;
  logic       counter_valid = 1'b0;
  logic [7:0] axi_data;
  logic       axi_valid;
  logic       axi_ready = 1'b0;
  logic [3:0] fifo_level;
  logic       overflow;
  logic [7:0] drop_count;

  tdc_frame_packer #(.DEPTH(DEPTH), .HEADER(HEADER)) dut (
    .clk(clk), .rst(rst), .counter_data(counter_data), .counter_valid(counter_valid),
    .axi_data(axi_data), .axi_valid(axi_valid), .axi_ready(axi_ready),
    .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] mq[$];       // samples waiting in the FIFO
  logic [7:0] m_bytes[$];  // bytes of the frame being sent (empty = idle)
  int         m_seq  = 0;
  bit         m_ovf  = 0;
  int         m_drop = 0;
  logic [7:0] exp_q[$];    // bytes the model says were transferred
  logic [7:0] obs_q[$];    // bytes the DUT actually transferred

  task automatic model_edge(input logic v, input logic [7:0] d, input logic r, input logic rs);
    bit pop;
    int sz0;
    logic [7:0] s, sq;
    if (rs) begin
      mq.delete(); m_bytes.delete(); m_seq = 0; m_ovf = 0; m_drop = 0;
      return;
    end
    sz0 = mq.size();
    pop = (m_bytes.size() == 0) && (sz0 > 0);
    if (m_bytes.size() != 0 && r) begin
      exp_q.push_back(m_bytes.pop_front());
      if (m_bytes.size() == 0) m_seq = (m_seq + 1) % 256;
    end
    if (pop) begin
      s  = mq.pop_front();
      sq = 8'(m_seq);
      m_bytes.push_back(HEADER);
      m_bytes.push_back(sq);
      m_bytes.push_back(s);
      if (FL == 4) m_bytes.push_back(HEADER ^ sq ^ s);
    end
    if (v) begin
      if (sz0 < int'(DEPTH) || pop) mq.push_back(d);
      else begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
    end
  endtask

  // One clock cycle: drive inputs, record any transfer, advance model, sample #1 after edge.
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic rs);
    counter_valid = v; counter_data = d; axi_ready = r; rst = rs;
    if (!rs && axi_valid === 1'b1 && r) obs_q.push_back(axi_data);
    @(posedge clk);
    model_edge(v, d, r, rs);
    #1;
  endtask

  task automatic drain(output bit ok);
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      if (m_bytes.size() == 0 && mq.size() == 0) begin
        step(1'b0, 8'h00, 1'b1, 1'b0);
        ok = 1;
        return;
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic restart();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    step($urandom_range(1), 8'($urandom), 1'b1, 1'b1);
    step($urandom_range(1), 8'($urandom), 1'b1, 1'b1);
    n_checks++; if (axi_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", axi_valid); end
    n_checks++; if (axi_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", axi_data); end
    n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_single();
    logic [7:0] want[$];
    restart();
    want = {8'hA5, 8'h00, 8'h3C};
    if (FL == 4) want.push_back(8'h99);
    step(1'b1, 8'h3C, 1'b1, 1'b0);
    n_checks++; if (axi_valid !== 1'b0) begin n_fail++; $display("FAIL single_n1_valid got=%b exp=0", axi_valid); end
    n_checks++; if (fifo_level !== 4'd1) begin n_fail++; $display("FAIL single_n1_level got=%0d exp=1", fifo_level); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < FL; i++) begin
      n_checks++; if (axi_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid[%0d] got=%b exp=1", i, axi_valid); end
      n_checks++; if (axi_data !== want[i]) begin n_fail++; $display("FAIL single_byte[%0d] got=%h exp=%h", i, axi_data, want[i]); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    n_checks++; if (axi_valid !== 1'b0) begin n_fail++; $display("FAIL single_after_valid got=%b exp=0", axi_valid); end
  endtask

  task automatic test_backpressure();
    bit ok;
    restart();
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (axi_data !== 8'h00 || axi_valid !== 1'b1) begin n_fail++; $display("FAIL bp_seq_enter got=%b/%h exp=1/00", axi_valid, axi_data); end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++; if (axi_valid !== 1'b1 || axi_data !== 8'h00) begin n_fail++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/00", i, axi_valid, axi_data); end
    end
    drain(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_drain_timeout got=0 exp=1"); end
    n_checks++; if (obs_q.size() != FL) begin n_fail++; $display("FAIL bp_len got=%0d exp=%0d", obs_q.size(), FL); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_byte[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [7:0] want[$];
    restart();
    for (int k = 1; k <= 12; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
    n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL ovf_level got=%0d exp=8", fifo_level); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    n_checks++; if (drop_count !== 8'd3) begin n_fail++; $display("FAIL ovf_drops got=%0d exp=3", drop_count); end
    n_checks++; if (axi_valid !== 1'b1 || axi_data !== HEADER) begin n_fail++; $display("FAIL ovf_hdr got=%b/%h exp=1/a5", axi_valid, axi_data); end
    drain(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_drain_timeout got=0 exp=1"); end
    for (int k = 1; k <= 9; k++) begin
      want.push_back(HEADER); want.push_back(8'(k - 1)); want.push_back(8'(k));
      if (FL == 4) want.push_back(HEADER ^ 8'(k - 1) ^ 8'(k));
    end
    n_checks++; if (obs_q.size() != want.size()) begin n_fail++; $display("FAIL ovf_len got=%0d exp=%0d", obs_q.size(), want.size()); end
    for (int i = 0; i < obs_q.size() && i < want.size(); i++) begin
      n_checks++; if (obs_q[i] !== want[i]) begin n_fail++; $display("FAIL ovf_byte[%0d] got=%h exp=%h", i, obs_q[i], want[i]); end
    end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_push_full_pop();
    bit ok;
    restart();
    for (int k = 0; k < 9; k++) step(1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
    n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL pf_fill got=%0d exp=8", fifo_level); end
    for (int k = 0; k < FL; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (axi_valid !== 1'b0 || fifo_level !== 4'd8) begin n_fail++; $display("FAIL pf_idle got=%b/%0d exp=0/8", axi_valid, fifo_level); end
    step(1'b1, 8'h55, 1'b0, 1'b0);
    n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL pf_level got=%0d exp=8", fifo_level); end
    n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL pf_drops got=%0d exp=0", drop_count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pf_ovf got=%b exp=0", overflow); end
    drain(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL pf_drain_timeout got=0 exp=1"); end
    n_checks++; if (obs_q.size() != 10 * FL) begin n_fail++; $display("FAIL pf_len got=%0d exp=%0d", obs_q.size(), 10 * FL); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL pf_byte[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_seq_wrap();
    bit ok;
    restart();
    for (int f = 0; f < 257; f++) begin
      step(1'b1, 8'($urandom), 1'b1, 1'b0);
      for (int c = 0; c < 5; c++) step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    drain(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_drain_timeout got=0 exp=1"); end
    n_checks++; if (obs_q.size() != 257 * FL) begin n_fail++; $display("FAIL wrap_len got=%0d exp=%0d", obs_q.size(), 257 * FL); end
    n_checks++; if (obs_q[255 * FL + 1] !== 8'hFF) begin n_fail++; $display("FAIL wrap_seq256 got=%h exp=ff", obs_q[255 * FL + 1]); end
    n_checks++; if (obs_q[256 * FL + 1] !== 8'h00) begin n_fail++; $display("FAIL wrap_seq257 got=%h exp=00", obs_q[256 * FL + 1]); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_byte[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    restart();
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (axi_valid !== 1'b1 || axi_data !== 8'h11 || fifo_level !== 4'd3) begin
      n_fail++; $display("FAIL mid_dat got=%b/%h/%0d exp=1/11/3", axi_valid, axi_data, fifo_level); end
    step(1'b1, 8'h99, 1'b0, 1'b1);
    n_checks++; if (axi_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got=%b exp=0", axi_valid); end
    n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL mid_level got=%0d exp=0", fifo_level); end
    obs_q.delete(); exp_q.delete();
    step(1'b1, 8'h77, 1'b1, 1'b0);
    drain(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_drain_timeout got=0 exp=1"); end
    n_checks++; if (obs_q.size() != FL) begin n_fail++; $display("FAIL mid_len got=%0d exp=%0d", obs_q.size(), FL); end
    n_checks++; if (obs_q[1] !== 8'h00 || obs_q[2] !== 8'h77) begin n_fail++; $display("FAIL mid_frame got=%h/%h exp=00/77", obs_q[1], obs_q[2]); end
  endtask

  task automatic test_random();
    bit ok;
    logic [3:0] e_lvl;
    restart();
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(2) == 0, 8'($urandom), 1'($urandom_range(1)), $urandom_range(599) == 0);
      e_lvl = 4'(mq.size());
      n_checks++; if (fifo_level !== e_lvl) begin n_fail++; $display("FAIL rnd_level[%0d] got=%0d exp=%0d", c, fifo_level, e_lvl); end
      n_checks++; if (axi_valid !== (m_bytes.size() != 0)) begin n_fail++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", c, axi_valid, m_bytes.size() != 0); end
      if (m_bytes.size() != 0) begin
        n_checks++; if (axi_data !== m_bytes[0]) begin n_fail++; $display("FAIL rnd_data[%0d] got=%h exp=%h", c, axi_data, m_bytes[0]); end
      end
      n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf[%0d] got=%b exp=%b", c, overflow, m_ovf); end
      n_checks++; if (drop_count !== 8'(m_drop)) begin n_fail++; $display("FAIL rnd_drop[%0d] got=%0d exp=%0d", c, drop_count, m_drop); end
    end
    drain(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rnd_drain_timeout got=0 exp=1"); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_len got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_byte[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_push_full_pop();
    test_seq_wrap();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
